// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential packed-BCD to binary converter. Consumes one BCD digit per
// clock, most significant digit first, with Horner's rule:
//    acc = acc*10 + digit
// A word is accepted with a valid/ready handshake on the input side. The
// result is offered with a valid/ready handshake on the output side.
//
// Parameters
//    DIGITS  number of BCD digits in in_bcd (1..9)
//    BIN_W   width of the binary result, >= ceil(log2(10^DIGITS))
//
// Ports
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_bcd     packed BCD word, MSD in in_bcd[4*DIGITS-1 -: 4]
//    in_valid   in_bcd is valid
//    in_ready   converter can accept a word (IDLE)
//    out_bin    binary result; holds its value until the next result
//    out_valid  out_bin (and err) valid (DONE)
//    out_ready  consumer takes the result
//    err        illegal digit (>9) seen; only with BCD2BIN_ERR_EN
//
// Optional feature macro: BCD2BIN_ERR_EN
//    Defined   : digits > 9 set a sticky flag; the result is then err=1 and
//                out_bin=0.
//    Undefined : no err port. Illegal nibbles enter the arithmetic at their
//                raw value, and the result wraps to BIN_W bits.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   in_bcd,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BIN_W-1:0]      out_bin,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef BCD2BIN_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [4*DIGITS-1:0]   shift_reg;
   logic [BIN_W-1:0]      acc;
   logic [BIN_W-1:0]      acc_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [3:0]            cur_digit;
   logic                  last_digit;

   // acc*10 + d, formed as (acc<<3)+(acc<<1) in BIN_W+4 bits, then
   // truncated back to BIN_W. Legal digits and widths never truncate.
   function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] a,
                                                  input logic [3:0]       d);
      logic [BIN_W+3:0] wide;
      wide = ({4'b0000, a} << 3) + ({4'b0000, a} << 1) + {{BIN_W{1'b0}}, d};
      return wide[BIN_W-1:0];
   endfunction

   assign cur_digit  = shift_reg[4*DIGITS-1 -: 4];
   assign acc_nxt    = mul10_add(acc, cur_digit);
   assign last_digit = (cnt == '0);

`ifdef BCD2BIN_ERR_EN
   logic err_flag;
   logic err_nxt;

   function automatic logic digit_bad(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

   // Includes the digit being consumed this edge, so an illegal last
   // digit is still reported in the registered result.
   assign err_nxt = err_flag | digit_bad(cur_digit);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = CONV;
            end
         end
         CONV: begin
            if (last_digit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture on accept, one Horner step per CONV edge, register
   // the result on the edge that consumes the final digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_bin   <= '0;
`ifdef BCD2BIN_ERR_EN
         err_flag  <= 1'b0;
         err       <= 1'b0;
`endif
      end else if (state == IDLE) begin
         if (in_valid) begin
            shift_reg <= in_bcd;
            acc       <= '0;
            cnt       <= CNT_W'(DIGITS - 1);
`ifdef BCD2BIN_ERR_EN
            err_flag  <= 1'b0;
`endif
         end
      end else if (state == CONV) begin
         acc       <= acc_nxt;
         shift_reg <= shift_reg << 4;
         cnt       <= cnt - CNT_W'(1);
`ifdef BCD2BIN_ERR_EN
         err_flag  <= err_nxt;
         if (last_digit) begin
            out_bin <= err_nxt ? '0 : acc_nxt;
            err     <= err_nxt;
         end
`else
         if (last_digit) begin
            out_bin <= acc_nxt;
         end
`endif
      end
   end

endmodule
